uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
// - UART receiver, 8N1 format: 1 start bit, 8 data bits sent LSB first, 1 stop bit, no parity.
// - Counterpart to the UART transmitter. Turns the serial rx_i line into bytes with a
//   one-cycle valid strobe for the measurement/debug logic.
// - Sits at the pin boundary. rx_i is asynchronous to clk_i.
// PARAMETERS
// - CLK_FREQ_HZ  default 100_000_000 : system clock frequency in Hz.
// - BAUD_RATE    default 115_200     : line rate in bit/s.
// - CLKS_PER_BIT (localparam) = CLK_FREQ_HZ/BAUD_RATE, integer-truncated.
//   Elaboration error if it is < 4.
// PORTS
// - clk_i        in   1  system clock.
// - reset_ni     in   1  asynchronous reset, active low.
// - rx_i         in   1  serial UART input. Idle level is high.
// - data_o       out  8  last correctly received byte. Held until the next good frame.
// - valid_o      out  1  one-cycle pulse: data_o was updated this cycle.
// - frame_err_o  out  1  one-cycle pulse: stop bit was sampled low.
// - busy_o       out  1  high while a frame is being received (state != IDLE).
// BEHAVIOUR
// - Reset values: data_o=8'h00, valid_o=0, frame_err_o=0, busy_o=0. Synchronizer flops
//   reset to 1. FSM resets to IDLE.
// - Reset is asynchronous, so asserting it mid-frame aborts the frame immediately.
//   No valid_o or error pulse is produced for the aborted frame.
// - Input path: two-flop synchronizer, rx_i -> rx_s. Falling-edge detect on rx_s
//   uses one extra flop.
// - One bit-timer counter and one 3-bit bit index. The counter reloads on every state
//   entry and on every sample.
// - FSM states and transitions:
//   - IDLE: a falling edge on rx_s loads the timer with CLKS_PER_BIT/2 - 1 and moves to START.
//   - START: when the timer expires (mid start bit), sample rx_s.
//     - rx_s=1: glitch. Return to IDLE with no outputs.
//     - rx_s=0: move to DATA with bit index 0 and timer = CLKS_PER_BIT-1.
//   - DATA: on each timer expiry, shift rx_s into bit [index]. LSB is received first.
//     After index 7, move to STOP.
//   - STOP: on timer expiry, sample rx_s.
//     - rx_s=1: in the next cycle data_o <= shift register and valid_o=1. Then IDLE.
//     - rx_s=0: frame_err_o=1 for one cycle. data_o is not changed. Move to BREAK.
//   - BREAK: wait until rx_s=1, then go to IDLE. This prevents a held-low line from
//     retriggering a start.
// - Latency: valid_o asserts 2 (synchronizer) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles
//   after the rx_i falling edge, ±1 cycle for synchronizer phase.
// - Back-to-back frames: returning to IDLE at mid stop bit leaves half a bit of margin.
//   A start edge that arrives right after the stop sample must be caught, including on the
//   same cycle valid_o pulses.
// - valid_o and frame_err_o are never high in the same cycle.
// - No backpressure. The consumer must capture data_o on valid_o. An unread byte is
//   overwritten by the next good frame.
// - All outputs are registered.
// STRUCTURE
// - uart_pkg (shared with the transmitter):
//   - typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t
//   - localparam UART_DATA_BITS = 8
//   - function clks_per_bit(freq, baud)
// - Sub-module uart_baud_cnt: loadable down-counter with a tick-on-zero output.
//   Reusable by the transmitter.
// - Synchronizer and FSM live in this file.
// TESTING
// - All tests use CLK_FREQ_HZ=16_000_000 and BAUD_RATE=1_000_000, so CLKS_PER_BIT=16.
// - Single byte: drive 8'hA5 as 8N1 at 16 clk/bit.
//   -> one valid_o pulse, data_o=8'hA5, frame_err_o stays 0.
// - Back-to-back: 8'h00, 8'hFF, 8'h55 with no idle gap.
//   -> three valid_o pulses in order with matching data_o.
// - Glitch: rx_i low for 4 clk, then high.
//   -> no valid_o, busy_o drops within 10 clk, FSM back in IDLE.
// - Framing error: send 8'h3C with stop bit = 0, hold low 40 clk, then release and send 8'h81.
//   -> frame_err_o pulses once, data_o keeps its previous value, then valid_o with 8'h81.
// - Reset mid-frame: assert reset_ni during data bit 4 of 8'h96, release, send 8'h42.
//   -> all outputs 0 during reset, no stale pulse, then valid_o with 8'h42.
// - Baud tolerance: send 8'hC3 at +3% and -3% bit period.
//   -> data_o=8'hC3, frame_err_o=0 in both cases.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and the
// bit-period helper used by both the receiver and the transmitter.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

    localparam int UART_DATA_BITS = 8;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable down-counter that parks at zero; tick_o marks the expiry of the
// loaded interval and stays high until the next load.
`timescale 1ns/1ps
module uart_baud_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             tick_o
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_count <= '0;
        end else if (load_i) begin
            r_count <= load_val_i;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign tick_o = (r_count == '0);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, falling-edge start detect,
// mid-bit sampling FSM, registered byte/valid/frame-error/busy outputs.
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115_200
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(UART_DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_rate
            $error("uart_rx: CLKS_PER_BIT must be at least 4");
        end
    endgenerate

    logic                      r_rxMeta;
    logic                      r_rxSync;
    logic                      r_rxPrev;
    uart_rx_state_t            r_state;
    logic [IDX_W-1:0]          r_bitIdx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [7:0]                r_data;
    logic                      r_valid;
    logic                      r_frameErr;
    logic                      r_busy;

    uart_rx_state_t            w_stateNext;
    logic                      w_load;
    logic [CNT_W-1:0]          w_loadVal;
    logic                      w_tick;
    logic                      w_fallEdge;

    // Idle-high line, so every synchronizer stage powers up at 1 to avoid a false start.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_rxMeta <= 1'b1;
            r_rxSync <= 1'b1;
            r_rxPrev <= 1'b1;
        end else begin
            r_rxMeta <= rx_i;
            r_rxSync <= r_rxMeta;
            r_rxPrev <= r_rxSync;
        end
    end

    assign w_fallEdge = r_rxPrev & ~r_rxSync;

    uart_baud_cnt #(
        .WIDTH      (CNT_W)
    ) u_baud_cnt (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .load_i     (w_load),
        .load_val_i (w_loadVal),
        .tick_o     (w_tick)
    );

    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        w_loadVal   = FULL_LOAD;
        case (r_state)
            IDLE: begin
                if (w_fallEdge) begin
                    w_stateNext = START;
                    w_load      = 1'b1;
                    w_loadVal   = HALF_LOAD;
                end
            end
            START: begin
                if (w_tick) begin
                    w_load      = 1'b1;
                    w_stateNext = r_rxSync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_load = 1'b1;
                    if (r_bitIdx == LAST_IDX) begin
                        w_stateNext = STOP;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_load      = 1'b1;
                    w_stateNext = r_rxSync ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (r_rxSync) begin
                    w_load      = 1'b1;
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Data is committed only after a high stop sample; a low stop leaves data_o untouched.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state    <= IDLE;
            r_bitIdx   <= '0;
            r_shift    <= '0;
            r_data     <= 8'h00;
            r_valid    <= 1'b0;
            r_frameErr <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_busy     <= (w_stateNext != IDLE);
            r_valid    <= 1'b0;
            r_frameErr <= 1'b0;
            if (r_state == START && w_tick && !r_rxSync) begin
                r_bitIdx <= '0;
            end
            if (r_state == DATA && w_tick) begin
                r_shift[r_bitIdx] <= r_rxSync;
                r_bitIdx          <= r_bitIdx + 1'b1;
            end
            if (r_state == STOP && w_tick) begin
                if (r_rxSync) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_frameErr <= 1'b1;
                end
            end
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign frame_err_o = r_frameErr;
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit: expected bytes are
// queued as frames are driven and popped when valid_o pulses.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam real CLK_NS = 10.0;
    localparam real BIT_NS = 160.0;

    logic       clk;
    logic       reset_ni;
    logic       rx;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       busy_o;

    logic [7:0] expQ[$];
    int         vectorCount = 0;
    int         missCount   = 0;
    int         errSeen     = 0;

    uart_rx #(
        .CLK_FREQ_HZ (16_000_000),
        .BAUD_RATE   (1_000_000)
    ) dut (
        .clk_i       (clk),
        .reset_ni    (reset_ni),
        .rx_i        (rx),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .frame_err_o (frame_err_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #(CLK_NS / 2.0) clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Drives one 8N1 frame; only frames with a high stop bit are expected back.
    task automatic applyStimulus(input logic [7:0] b, input real bitNs, input logic stopBit);
        if (stopBit) expQ.push_back(b);
        rx = 1'b0;
        #(bitNs);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bitNs);
        end
        rx = stopBit;
        #(bitNs);
    endtask

    task automatic waitDrain(input string tag);
        for (int i = 0; i < 400 && expQ.size() != 0; i++) @(negedge clk);
        checkOutput(tag, 32'(expQ.size()), 32'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_data"},  32'(data_o),      32'h00);
        checkOutput({tag, "_valid"}, 32'(valid_o),     32'h0);
        checkOutput({tag, "_ferr"},  32'(frame_err_o), 32'h0);
        checkOutput({tag, "_busy"},  32'(busy_o),      32'h0);
    endtask

    always @(negedge clk) begin
        if (reset_ni) begin
            if (valid_o || frame_err_o) begin
                checkOutput("validErrExclusive", 32'(valid_o & frame_err_o), 32'd0);
            end
            if (frame_err_o) errSeen++;
            if (valid_o) begin
                checkOutput("validExpected", 32'(expQ.size() > 0), 32'd1);
                if (expQ.size() > 0) begin
                    checkOutput("rxByte", 32'(data_o), 32'(expQ.pop_front()));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rx       = 1'b1;
        reset_ni = 1'b0;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        reset_ni = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] single byte");
        applyStimulus(8'hA5, BIT_NS, 1'b1);
        waitDrain("singleDrain");
        checkOutput("singleHold", 32'(data_o), 32'hA5);

        $display("[TB] back-to-back");
        applyStimulus(8'h00, BIT_NS, 1'b1);
        applyStimulus(8'hFF, BIT_NS, 1'b1);
        applyStimulus(8'h55, BIT_NS, 1'b1);
        waitDrain("b2bDrain");
        checkOutput("noErrSoFar", 32'(errSeen), 32'd0);

        $display("[TB] glitch");
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("glitchBusyHigh", 32'(busy_o), 32'd1);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("glitchBusyLow", 32'(busy_o), 32'd0);
        checkOutput("glitchHold", 32'(data_o), 32'h55);

        $display("[TB] framing error");
        applyStimulus(8'h3C, BIT_NS, 1'b0);
        repeat (40) @(negedge clk);
        rx = 1'b1;
        #(2.0 * BIT_NS);
        checkOutput("frameErrCount", 32'(errSeen), 32'd1);
        checkOutput("frameErrHold", 32'(data_o), 32'h55);
        applyStimulus(8'h81, BIT_NS, 1'b1);
        waitDrain("afterErrDrain");

        $display("[TB] reset mid-frame");
        begin
            logic [7:0] abortByte;
            abortByte = 8'h96;
            rx = 1'b0;
            #(BIT_NS);
            for (int i = 0; i < 4; i++) begin
                rx = abortByte[i];
                #(BIT_NS);
            end
            rx = abortByte[4];
            #(BIT_NS / 2.0);
            checkOutput("midFrameBusy", 32'(busy_o), 32'd1);
            reset_ni = 1'b0;
            #1;
            checkResetOutputs("midReset");
            rx = 1'b1;
            repeat (3) @(negedge clk);
            reset_ni = 1'b1;
            repeat (20) @(negedge clk);
        end
        applyStimulus(8'h42, BIT_NS, 1'b1);
        waitDrain("afterResetDrain");

        $display("[TB] baud tolerance");
        applyStimulus(8'hC3, BIT_NS * 1.03, 1'b1);
        waitDrain("slowDrain");
        checkOutput("slowData", 32'(data_o), 32'hC3);
        applyStimulus(8'hC3, BIT_NS * 0.97, 1'b1);
        waitDrain("fastDrain");
        checkOutput("fastData", 32'(data_o), 32'hC3);
        checkOutput("finalErrCount", 32'(errSeen), 32'd1);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
